// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - end-of-test monitor snooping the register-file write port
//
// Watches writes to DONE_REG, PASS_REG and TNUM_REG. A write of 1 to DONE_REG
// starts a settle window; when it expires the verdict is PASS when the shadowed
// PASS_REG value is 1, otherwise FAIL. A run that reaches TIMEOUT_CYCLES without
// a done write ends in TIMEOUT. Verdicts are sticky until clr or reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  arm monitor (level, sampled in IDLE)
//   clr                 synchronous return to IDLE, clears all outputs
//   wr_en/addr/data     register-file write port being snooped
//   done                verdict reached (pass | fail | timeout)
//   pass/fail/timeout   one-hot verdict
//   fail_testnum        test number latched on FAIL/TIMEOUT
//   cycle_cnt           saturating count of RUN+SETTLE cycles
//   led                 {fail|timeout, pass}
module riscv_test_monitor #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TNUM_REG       = 3,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [CPU_WIDTH-1:0]      wr_data,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [CPU_WIDTH-1:0]      fail_testnum,
    output logic [CNT_WIDTH-1:0]      cycle_cnt,
    output logic [1:0]                led
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_PASS    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;

    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    logic [2:0]           state;
    logic [SW-1:0]        settle_cnt;
    logic [CPU_WIDTH-1:0] pass_val;
    logic [CPU_WIDTH-1:0] tnum_val;

    logic                 addr_nz;
    logic                 hit_done;
    logic                 hit_pass;
    logic                 hit_tnum;
    logic [CPU_WIDTH-1:0] pass_now;
    logic [CPU_WIDTH-1:0] tnum_now;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 at_limit;

    // x0 is hard-wired zero in the core, so writes to it never count.
    assign addr_nz  = (wr_addr != '0);
    assign hit_done = wr_en && addr_nz && (wr_addr == REG_ADDR_WIDTH'(DONE_REG))
                      && (wr_data == CPU_WIDTH'(1));
    assign hit_pass = wr_en && addr_nz && (wr_addr == REG_ADDR_WIDTH'(PASS_REG));
    assign hit_tnum = wr_en && addr_nz && (wr_addr == REG_ADDR_WIDTH'(TNUM_REG));

    // Same-cycle writes are forwarded so the verdict edge sees the newest value.
    assign pass_now = hit_pass ? wr_data : pass_val;
    assign tnum_now = hit_tnum ? wr_data : tnum_val;

    assign cnt_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);
    assign at_limit = (cycle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            pass_val     <= '0;
            tnum_val     <= '0;
            fail_testnum <= '0;
            cycle_cnt    <= '0;
        end else if (clr) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            pass_val     <= '0;
            tnum_val     <= '0;
            fail_testnum <= '0;
            cycle_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state        <= S_RUN;
                        settle_cnt   <= '0;
                        pass_val     <= '0;
                        tnum_val     <= '0;
                        fail_testnum <= '0;
                        cycle_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cnt_next;
                    pass_val  <= pass_now;
                    tnum_val  <= tnum_now;
                    // A done write on the limit cycle takes precedence over timeout.
                    if (hit_done) begin
                        state      <= S_SETTLE;
                        settle_cnt <= SW'(SETTLE_CYCLES);
                    end else if (at_limit) begin
                        state        <= S_TIMEOUT;
                        fail_testnum <= tnum_now;
                    end
                end
                S_SETTLE: begin
                    cycle_cnt <= cnt_next;
                    pass_val  <= pass_now;
                    tnum_val  <= tnum_now;
                    if (settle_cnt == '0) begin
                        if (pass_now == CPU_WIDTH'(1)) begin
                            state <= S_PASS;
                        end else begin
                            state        <= S_FAIL;
                            fail_testnum <= tnum_now;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                S_PASS, S_FAIL, S_TIMEOUT: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only the state register, so there is no input-to-output path.
    assign pass    = (state == S_PASS);
    assign fail    = (state == S_FAIL);
    assign timeout = (state == S_TIMEOUT);
    assign done    = pass | fail | timeout;
    assign led     = {fail | timeout, pass};

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - scoreboard bench for riscv_test_monitor
module tb_riscv_test_monitor;

    localparam int S  = 1;
    localparam int TO = 100;
    localparam int N  = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycle_cnt;
    logic [1:0]  led;

    riscv_test_monitor #(
        .CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(3),
        .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt), .led(led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          p, f, t;
        logic [31:0] tnum;
        int          cnt;
        int          at;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    bit          sc_we   [N];
    logic [4:0]  sc_addr [N];
    logic [31:0] sc_data [N];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit outs_nz();
        return done | pass | fail | timeout | (|led) | (|fail_testnum) | (|cycle_cnt);
    endfunction

    // Reference: find the first qualifying done write inside the run window,
    // then replay the last pass/tnum writes up to the verdict cycle.
    function automatic exp_t model(int e);
        exp_t r;
        int k = -1;
        int v;
        logic [31:0] pv = 0, tv = 0;
        for (int i = 0; i < TO; i++)
            if (k < 0 && sc_we[i] && sc_addr[i] == 5'd26 && sc_data[i] == 32'd1) k = i;
        v = (k >= 0) ? k + 1 + S : TO - 1;
        for (int i = 0; i <= v; i++) begin
            if (sc_we[i] && sc_addr[i] == 5'd27) pv = sc_data[i];
            if (sc_we[i] && sc_addr[i] == 5'd3)  tv = sc_data[i];
        end
        r.t    = (k < 0);
        r.p    = (k >= 0) && (pv == 32'd1);
        r.f    = (k >= 0) && (pv != 32'd1);
        r.tnum = r.p ? 32'd0 : tv;
        r.cnt  = v + 1;
        r.at   = e + 1 + v;
        return r;
    endfunction

    // Monitor: pops one expectation each time a verdict appears.
    bit done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("pass", pass, x.p);
                check("fail", fail, x.f);
                check("timeout", timeout, x.t);
                check("fail_testnum", fail_testnum, x.tnum);
                check("cycle_cnt", cycle_cnt, x.cnt);
                check("led", led, {x.f | x.t, x.p});
                check("verdict_cycle", cyc, x.at);
            end
        end
        done_q <= done;
    end

    task automatic clear_sc();
        for (int i = 0; i < N; i++) begin
            sc_we[i] = 0; sc_addr[i] = '0; sc_data[i] = '0;
        end
    endtask

    task automatic set_wr(input int i, input bit we, input logic [4:0] a, input logic [31:0] d);
        sc_we[i] = we; sc_addr[i] = a; sc_data[i] = d;
    endtask

    task automatic start_run(output int e);
        @(negedge clk); clr = 1; en = 0; wr_en = 0;
        @(negedge clk); clr = 0;
        check("clr_clears", outs_nz(), 0);
        en = 1; e = cyc + 1;
        @(negedge clk); en = 0;
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = sc_we[i]; wr_addr = sc_addr[i]; wr_data = sc_data[i];
            @(negedge clk);
        end
        wr_en = 0;
    endtask

    task automatic run_scenario();
        int e;
        exp_t x;
        start_run(e);
        x = model(e);
        sb.push_back(x);
        drive(x.at - e + 2);
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            check("sb_drain", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        check("sticky_done", done, 1);
    endtask

    initial begin
        int e;
        int r;
        #2;
        check("reset_outs", outs_nz(), 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        check("idle_after_reset", outs_nz(), 0);

        // pass
        clear_sc(); set_wr(0,1,3,2); set_wr(1,1,27,1); set_wr(2,1,26,1); run_scenario();
        // fail
        clear_sc(); set_wr(0,1,3,5); set_wr(1,1,27,0); set_wr(2,1,26,1); run_scenario();
        // pass written in SETTLE, and on the verdict edge itself
        clear_sc(); set_wr(0,1,3,5); set_wr(1,1,27,0); set_wr(2,1,26,1); set_wr(3,1,27,1); run_scenario();
        clear_sc(); set_wr(0,1,3,5); set_wr(1,1,27,0); set_wr(2,1,26,1); set_wr(4,1,27,1); run_scenario();
        // timeout, then done on the last run cycle
        clear_sc(); set_wr(10,1,3,7); run_scenario();
        clear_sc(); set_wr(10,1,3,7); set_wr(TO-1,1,26,1); run_scenario();
        // filtering and no settle restart
        clear_sc(); set_wr(0,1,26,2); set_wr(1,1,0,1); set_wr(2,0,26,1); set_wr(3,1,27,1);
        set_wr(5,1,26,1); set_wr(6,1,26,1); run_scenario();
        // re-arm with cleared shadows after a pass
        clear_sc(); set_wr(0,1,26,1); run_scenario();

        // clr in the same cycle as the done write
        start_run(e);
        repeat (3) @(negedge clk);
        wr_en = 1; wr_addr = 26; wr_data = 1; clr = 1;
        @(negedge clk); wr_en = 0; clr = 0;
        check("clr_vs_done", outs_nz(), 0);
        repeat (5) @(negedge clk);
        check("clr_vs_done_idle", outs_nz(), 0);

        // asynchronous reset in SETTLE
        clear_sc(); set_wr(3,1,26,1);
        start_run(e);
        drive(4);
        check("settle_cnt_before_reset", cycle_cnt, 4);
        #2 rst_n = 0;
        #1 check("async_reset_outs", outs_nz(), 0);
        @(negedge clk); rst_n = 1;
        repeat (4) @(negedge clk);
        check("idle_after_async_reset", outs_nz(), 0);

        // randomized runs
        for (int s = 0; s < 30; s++) begin
            clear_sc();
            for (int i = 0; i < N; i++) begin
                sc_we[i] = ($urandom_range(0, 9) < 8);
                r = $urandom_range(0, 7);
                case (r)
                    0: sc_addr[i] = 0;
                    1: sc_addr[i] = 3;
                    2, 4: sc_addr[i] = 26;
                    3, 5: sc_addr[i] = 27;
                    default: sc_addr[i] = 5'($urandom);
                endcase
                r = $urandom_range(0, 3);
                case (r)
                    0: sc_data[i] = 0;
                    1: sc_data[i] = 1;
                    2: sc_data[i] = 2;
                    default: sc_data[i] = $urandom;
                endcase
            end
            run_scenario();
        end

        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
